// File: rtl/analog_out_pkg.sv
// Shared types and constants for the analog video output sequencer.
package analog_out_pkg;

  typedef enum logic [1:0] {
    MODE_RGBS  = 2'd0,
    MODE_RGSB  = 2'd1,
    MODE_YPBPR = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ARMED = 2'd1,
    ST_MUTE  = 2'd2
  } state_e;

  localparam logic [23:0] BLACK_RGB   = 24'h000000;
  localparam logic [23:0] BLACK_YPBPR = 24'h800080;

  function automatic logic [23:0] black_of(mode_e m);
    return (m == MODE_YPBPR) ? BLACK_YPBPR : BLACK_RGB;
  endfunction

  // Luma / green carries sync in RGsB and YPbPr.
  function automatic logic sog_of(mode_e m);
    return (m == MODE_RGSB) || (m == MODE_YPBPR);
  endfunction

endpackage

// File: rtl/video_delay_line.sv
// Fixed-depth register delay with synchronous flush to RESET_VAL.
module video_delay_line #(
  parameter int              WIDTH     = 26,
  parameter int              DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= RESET_VAL;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/analog_out_mode_ctrl.sv
// Analog output mode sequencer: vsync-aligned mode switching, post-switch mute,
// latency-matched RGB/sync delay and DAC output mux. Mute feature: ANALOG_MODE_MUTE_EN.
module analog_out_mode_ctrl
  import analog_out_pkg::*;
#(
  parameter int         CONV_LAT    = 3,
  parameter int         MUTE_FRAMES = 2,
  parameter logic [1:0] RESET_MODE  = 2'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mode_req,
  input  logic        mode_req_valid,
  output logic        mode_req_ready,
  input  logic        vsync,
  input  logic        csync,
  input  logic        de,
  input  logic [23:0] rgb_in,
  output logic [23:0] conv_din,
  input  logic [23:0] conv_dout,
  output logic [23:0] video_out,
  output logic        csync_out,
  output logic        de_out,
  output logic        sog_en,
  output logic [1:0]  mode_active,
  output logic        muted
);

  state_e state, state_n;
  mode_e  mode_q, mode_n, pend_q, pend_n;
  logic   vsync_d;
  logic   vs_rise;

`ifdef ANALOG_MODE_MUTE_EN
  localparam logic [3:0] MUTE_N = 4'(MUTE_FRAMES);
  logic [3:0] cnt_q, cnt_n;
`else
  logic unused_mute_frames;
  assign unused_mute_frames = ^MUTE_FRAMES;
`endif

  assign vs_rise  = vsync & ~vsync_d;
  assign conv_din = rgb_in;
  assign mode_active = mode_q;

  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    pend_n  = pend_q;
`ifdef ANALOG_MODE_MUTE_EN
    cnt_n   = cnt_q;
`endif
    case (state)
      ST_RUN: begin
        // Same-mode and reserved requests are swallowed without disturbing output.
        if (mode_req_valid && mode_req_ready &&
            mode_req != mode_q && mode_req != MODE_RSVD) begin
          pend_n  = mode_e'(mode_req);
          state_n = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (vs_rise) begin
          mode_n = pend_q;
`ifdef ANALOG_MODE_MUTE_EN
          cnt_n   = '0;
          state_n = (MUTE_FRAMES == 0) ? ST_RUN : ST_MUTE;
`else
          state_n = ST_RUN;
`endif
        end
      end
`ifdef ANALOG_MODE_MUTE_EN
      ST_MUTE: begin
        if (vs_rise) begin
          cnt_n = cnt_q + 4'd1;
          if (cnt_n == MUTE_N) state_n = ST_RUN;
        end
      end
`endif
      default: state_n = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_RUN;
      mode_q         <= mode_e'(RESET_MODE);
      pend_q         <= mode_e'(RESET_MODE);
      vsync_d        <= 1'b0;
      mode_req_ready <= 1'b0;
      sog_en         <= sog_of(mode_e'(RESET_MODE));
    end else begin
      state          <= state_n;
      mode_q         <= mode_n;
      pend_q         <= pend_n;
      vsync_d        <= vsync;
      mode_req_ready <= (state_n == ST_RUN);
      sog_en         <= sog_of(mode_n);
    end
  end

`ifdef ANALOG_MODE_MUTE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      muted <= 1'b0;
    end else begin
      cnt_q <= cnt_n;
      muted <= (state_n == ST_MUTE);
    end
  end
`else
  assign muted = 1'b0;
`endif

  // Raw path delayed to line up with the converter's output.
  logic [23:0] dly_rgb;
  logic        dly_cs, dly_de;

  video_delay_line #(
    .WIDTH    (26),
    .DEPTH    (CONV_LAT),
    .RESET_VAL({1'b1, 1'b0, 24'h000000})
  ) u_dly (
    .clk  (clk),
    .reset(reset),
    .din  ({csync, de, rgb_in}),
    .dout ({dly_cs, dly_de, dly_rgb})
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      video_out <= '0;
      csync_out <= 1'b1;
      de_out    <= 1'b0;
    end else begin
      csync_out <= dly_cs;
      de_out    <= dly_de;
      if (muted || !dly_de)         video_out <= black_of(mode_q);
      else if (mode_q == MODE_YPBPR) video_out <= conv_dout;
      else                           video_out <= dly_rgb;
    end
  end

endmodule
